wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter between the functional units (ALU, LDST, BRANCH, MATRIX) and the single register-file write port. Each cycle it picks one completing unit round-robin and registers that unit's result onto the writeback port. In the same cycle it drives the register-status-table clear, which releases the WAW hazard that dispatch checks against `rst[rd].busy`. Back-pressure to losing units is through a per-unit ready.

## Interface
Parameters:
- `NUM_FU`, 4: number of requesting units; index 0=ALU, 1=LDST, 2=BRANCH, 3=MATRIX.
- `REG_W`, 5: register index width.
- `DATA_W`, 32: result width.
- `CNT_W`, 16: conflict counter width.

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  synchronous active-high reset.
- `fu_valid`  in  NUM_FU  unit i has a result.
- `fu_rd`  in  NUM_FU*REG_W  destination register; slice i belongs to unit i.
- `fu_data`  in  NUM_FU*DATA_W  result data; slice i belongs to unit i.
- `fu_ready`  out  NUM_FU  one-hot grant; the unit i result is consumed when `fu_valid[i] & fu_ready[i]`.
- `freeze`  in  1  pipeline stall; the writeback stage holds.
- `flush`  in  1  squash the registered writeback.
- `wb_valid`  out  1  writeback stage occupied.
- `wb_wen`  out  1  register-file write enable; equals `wb_valid & (wb_rd != 0)`.
- `wb_rd`  out  REG_W  write index.
- `wb_data`  out  DATA_W  write data.
- `wb_fu`  out  $clog2(NUM_FU)  index of the unit that produced the writeback.
- `rst_clr`  out  1  clear the busy bit of `wb_rd` in the register status table; equals `wb_wen`.
- `conflicts`  out  CNT_W  saturating count of cycles with at least 2 valid requests.

## Operation
- `accept = ~flush & (~freeze | ~wb_valid)`.
- Grant, combinational:
  - Scan `fu_valid` starting at pointer `ptr` and wrapping mod NUM_FU.
  - The first valid unit is granted: `fu_ready[i]=1` only when `accept`.
  - At most one bit of `fu_ready` is high. `fu_ready` is never high for a non-valid unit.
- On a handshake with unit g:
  - `wb_valid<=1`, `wb_rd<=fu_rd[g]`, `wb_data<=fu_data[g]`, `wb_fu<=g`.
  - `ptr<=(g+1) mod NUM_FU`.
- No handshake:
  - `freeze & wb_valid & ~flush`: all `wb_*` hold and `ptr` holds.
  - Otherwise `wb_valid<=0`; `wb_rd`, `wb_data` and `wb_fu` hold their last value. `ptr` holds.
- Flush:
  - `wb_valid<=0` next cycle; flush wins over freeze.
  - No grant in the flush cycle, so units keep their requests.
  - `ptr` unchanged.
- `rd==0` results are granted and consumed normally. `wb_valid=1` but `wb_wen=rst_clr=0`.
- Conflict counter: increments when popcount(`fu_valid`)>=2 and `RST=0`, regardless of `accept`. It saturates at all-ones.
- Reset, synchronous: `wb_valid=0`, `wb_rd=0`, `wb_data=0`, `wb_fu=0`, `ptr=0`, `conflicts=0`. Combinationally `wb_wen=rst_clr=0`. `fu_ready` is combinational and is 0 while `wb_valid=0` only if no `fu_valid`; RST does not gate it.

## Timing
- Latency is 1 cycle: a handshake at edge t appears on `wb_*` and `rst_clr` during cycle t+1.
- Throughput is one writeback per cycle while `~freeze`. Back-to-back grants are allowed, so a drained stage accepts in the same cycle.
- Under freeze with the stage occupied, no grant is issued: `fu_ready=0` and a unit must hold `valid`, `rd` and `data`. Under freeze with the stage empty, one grant is accepted; the next cycle holds.
- Pointer update takes effect the cycle after a grant. With all units requesting continuously, grants follow 0,1,2,3,0...
- A request that keeps `valid` high is granted within NUM_FU accepting cycles.
- `flush` in the same cycle as RST: reset dominates.

## Test plan
- Reset then single request: assert RST for 2 cycles, release, then drive `fu_valid=0100`, `fu_rd[2]=7`, `fu_data[2]=0xDEADBEEF`. Required: `fu_ready=0100` same cycle; next cycle `wb_valid=1`, `wb_rd=7`, `wb_data=0xDEADBEEF`, `wb_fu=2`, `rst_clr=1`; then `ptr=3`.
- Round-robin fairness: from reset hold `fu_valid=1111` for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3; `conflicts=8`.
- Freeze: with `wb_valid=1` holding `rd=5`, assert `freeze` for 3 cycles with `fu_valid=0001`. Required: `fu_ready=0` throughout and `wb_*` unchanged. On release, unit 0 is granted in the same cycle and appears the next cycle.
- Flush beats freeze: `wb_valid=1`, assert `flush=1` and `freeze=1` together with `fu_valid=0010`. Required: `fu_ready=0`; next cycle `wb_valid=0`. After flush deasserts, unit 1 is granted.
- Register zero: unit 3 completes with `rd=0`. Required: handshake occurs, `wb_valid=1`, `wb_wen=0`, `rst_clr=0`.
- Counter saturation with `CNT_W=4`: 20 cycles of `fu_valid=0011`. Required: `conflicts` stops at 15. RST mid-run returns `conflicts=0`, `wb_valid=0` and `ptr=0` at the next edge.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: unit completion requests in, arbitrated register-file writeback out.
interface wb_arbiter_if #(
    parameter int NUM_FU = 4,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    localparam int FU_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU*REG_W-1:0]  fu_rd;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0]        fu_ready;
    logic                     freeze;
    logic                     flush;
    logic                     wb_valid;
    logic                     wb_wen;
    logic [REG_W-1:0]         wb_rd;
    logic [DATA_W-1:0]        wb_data;
    logic [FU_W-1:0]          wb_fu;
    logic                     rst_clr;
    logic [CNT_W-1:0]         conflicts;
    modport slave (
        input  fu_valid, fu_rd, fu_data, freeze, flush,
        output fu_ready, wb_valid, wb_wen, wb_rd, wb_data, wb_fu, rst_clr, conflicts
    );
    modport master (
        output fu_valid, fu_rd, fu_data, freeze, flush,
        input  fu_ready, wb_valid, wb_wen, wb_rd, wb_data, wb_fu, rst_clr, conflicts
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin pick of one completing unit per cycle onto the register-file write port.
module wb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic        CLK,
    input logic        RST,
    wb_arbiter_if.slave bus
);
    localparam int FU_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    logic [FU_W-1:0]   ptr;
    logic [FU_W-1:0]   gnt_idx;
    logic [FU_W-1:0]   idx;
    logic              gnt_any;
    logic              accept;
    logic              hs;
    logic              multi;
    logic              wb_valid_q;
    logic [REG_W-1:0]  wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [FU_W-1:0]   wb_fu_q;
    logic [CNT_W-1:0]  conflicts_q;
    assign accept = ~bus.flush & (~bus.freeze | ~wb_valid_q);
    assign hs     = gnt_any & accept;
    assign multi  = |(bus.fu_valid & (bus.fu_valid - 1'b1));
    // Scan backwards so the unit closest to ptr is the last (winning) assignment.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            idx = FU_W'((int'(ptr) + k) % NUM_FU);
            if (bus.fu_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_fu_q     <= '0;
            ptr         <= '0;
            conflicts_q <= '0;
        end else begin
            if (hs) begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= bus.fu_rd[gnt_idx*REG_W +: REG_W];
                wb_data_q  <= bus.fu_data[gnt_idx*DATA_W +: DATA_W];
                wb_fu_q    <= gnt_idx;
                ptr        <= (gnt_idx == FU_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (~(bus.freeze & wb_valid_q & ~bus.flush)) begin
                wb_valid_q <= 1'b0;
            end
            if (multi & ~&conflicts_q) conflicts_q <= conflicts_q + 1'b1;
        end
    end
    assign bus.fu_ready  = hs ? NUM_FU'(1) << gnt_idx : '0;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_fu     = wb_fu_q;
    assign bus.wb_wen    = wb_valid_q & |wb_rd_q;
    assign bus.rst_clr   = wb_valid_q & |wb_rd_q;
    assign bus.conflicts = conflicts_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic against a queue-free behavioural model.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    // Reference model state, updated from the rules at each rising edge
    int          m_ptr, m_fu, m_cnt;
    bit          m_v;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    wb_arbiter_if #(.NUM_FU(4), .REG_W(5), .DATA_W(32), .CNT_W(4)) b();
    wb_arbiter #(.NUM_FU(4), .REG_W(5), .DATA_W(32), .CNT_W(4)) dut (
        .CLK(clk), .RST(rst), .bus(b.slave)
    );
    always #5 clk = ~clk;
    function automatic int model_grant();
        for (int k = 0; k < 4; k++)
            if (b.fu_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction
    function automatic logic [3:0] model_ready();
        int g = model_grant();
        bit acc = !b.flush && (!b.freeze || !m_v);
        return (acc && g >= 0) ? 4'(1 << g) : 4'b0;
    endfunction
    task automatic tick();
        int g = model_grant();
        bit acc = !b.flush && (!b.freeze || !m_v);
        if (rst) begin
            m_v = 0; m_rd = 0; m_data = 0; m_fu = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (acc && g >= 0) begin
                m_v = 1; m_rd = b.fu_rd[g*5 +: 5]; m_data = b.fu_data[g*32 +: 32];
                m_fu = g; m_ptr = (g + 1) % 4;
            end else if (!(b.freeze && m_v && !b.flush)) m_v = 0;
            if ($countones(b.fu_valid) >= 2 && m_cnt < 15) m_cnt++;
        end
        @(posedge clk); #1;
    endtask
    task automatic set_unit(input int i, input logic [4:0] rd, input logic [31:0] data);
        b.fu_rd[i*5 +: 5]    = rd;
        b.fu_data[i*32 +: 32] = data;
    endtask
    task automatic do_reset();
        rst = 1; tick(); tick(); rst = 0;
    endtask
    task automatic test_reset();
        b.fu_valid = 0; b.fu_rd = '1; b.fu_data = '1; b.freeze = 0; b.flush = 0;
        do_reset();
        checks++; if (b.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %0h want 0", b.wb_valid); end
        checks++; if (b.wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd got %0h want 0", b.wb_rd); end
        checks++; if (b.wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data got %0h want 0", b.wb_data); end
        checks++; if (b.wb_fu !== 2'd0) begin errors++; $display("FAIL reset_wb_fu got %0h want 0", b.wb_fu); end
        checks++; if (b.conflicts !== 4'd0) begin errors++; $display("FAIL reset_conflicts got %0h want 0", b.conflicts); end
        checks++; if ({b.wb_wen, b.rst_clr} !== 2'b00) begin errors++; $display("FAIL reset_wen_clr got %0b want 00", {b.wb_wen, b.rst_clr}); end
    endtask
    task automatic test_single();
        set_unit(2, 5'd7, 32'hDEADBEEF);
        b.fu_valid = 4'b0100; #1;
        checks++; if (b.fu_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", b.fu_ready); end
        tick(); b.fu_valid = 0;
        checks++; if (b.wb_valid !== 1'b1) begin errors++; $display("FAIL single_wb_valid got %0h want 1", b.wb_valid); end
        checks++; if (b.wb_rd !== 5'd7) begin errors++; $display("FAIL single_wb_rd got %0d want 7", b.wb_rd); end
        checks++; if (b.wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wb_data got %0h want deadbeef", b.wb_data); end
        checks++; if (b.wb_fu !== 2'd2) begin errors++; $display("FAIL single_wb_fu got %0d want 2", b.wb_fu); end
        checks++; if (b.rst_clr !== 1'b1) begin errors++; $display("FAIL single_rst_clr got %0h want 1", b.rst_clr); end
        b.fu_valid = 4'b1111; #1;
        checks++; if (b.fu_ready !== 4'b1000) begin errors++; $display("FAIL single_ptr3 got %b want 1000", b.fu_ready); end
        b.fu_valid = 0;
    endtask
    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) set_unit(i, 5'(i + 10), 32'(32'hA000 + i));
        b.fu_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (b.fu_ready !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", i, b.fu_ready, 4'(1 << (i % 4))); end
            tick();
            checks++; if (b.wb_fu !== 2'(i % 4) || b.wb_data !== 32'(32'hA000 + i % 4)) begin errors++; $display("FAIL rr_wb[%0d] got fu=%0d data=%0h want fu=%0d", i, b.wb_fu, b.wb_data, i % 4); end
        end
        b.fu_valid = 0;
        checks++; if (b.conflicts !== 4'd8) begin errors++; $display("FAIL rr_conflicts got %0d want 8", b.conflicts); end
    endtask
    task automatic test_freeze();
        set_unit(1, 5'd5, 32'h5555); b.fu_valid = 4'b0010;
        tick();
        set_unit(0, 5'd9, 32'h9999); b.fu_valid = 4'b0001; b.freeze = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (b.fu_ready !== 4'b0000) begin errors++; $display("FAIL freeze_ready[%0d] got %b want 0000", i, b.fu_ready); end
            checks++; if (b.wb_valid !== 1'b1 || b.wb_rd !== 5'd5 || b.wb_data !== 32'h5555 || b.wb_fu !== 2'd1) begin
                errors++; $display("FAIL freeze_hold[%0d] got v=%0d rd=%0d data=%0h fu=%0d want 1/5/5555/1", i, b.wb_valid, b.wb_rd, b.wb_data, b.wb_fu); end
            tick();
        end
        b.freeze = 0; #1;
        checks++; if (b.fu_ready !== 4'b0001) begin errors++; $display("FAIL freeze_release_ready got %b want 0001", b.fu_ready); end
        tick(); b.fu_valid = 0;
        checks++; if (b.wb_fu !== 2'd0 || b.wb_rd !== 5'd9) begin errors++; $display("FAIL freeze_release_wb got fu=%0d rd=%0d want 0/9", b.wb_fu, b.wb_rd); end
    endtask
    task automatic test_flush();
        set_unit(1, 5'd3, 32'h1111);
        b.flush = 1; b.freeze = 1; b.fu_valid = 4'b0010; #1;
        checks++; if (b.fu_ready !== 4'b0000) begin errors++; $display("FAIL flush_ready got %b want 0000", b.fu_ready); end
        tick();
        checks++; if (b.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wb_valid got %0h want 0", b.wb_valid); end
        b.flush = 0; b.freeze = 0; #1;
        checks++; if (b.fu_ready !== 4'b0010) begin errors++; $display("FAIL flush_after_ready got %b want 0010", b.fu_ready); end
        tick(); b.fu_valid = 0;
        checks++; if (b.wb_valid !== 1'b1 || b.wb_fu !== 2'd1) begin errors++; $display("FAIL flush_after_wb got v=%0d fu=%0d want 1/1", b.wb_valid, b.wb_fu); end
    endtask
    task automatic test_rd_zero();
        set_unit(3, 5'd0, 32'hC0DE);
        b.fu_valid = 4'b1000; #1;
        checks++; if (b.fu_ready !== 4'b1000) begin errors++; $display("FAIL rd0_ready got %b want 1000", b.fu_ready); end
        tick(); b.fu_valid = 0;
        checks++; if (b.wb_valid !== 1'b1 || b.wb_fu !== 2'd3) begin errors++; $display("FAIL rd0_wb got v=%0d fu=%0d want 1/3", b.wb_valid, b.wb_fu); end
        checks++; if ({b.wb_wen, b.rst_clr} !== 2'b00) begin errors++; $display("FAIL rd0_wen_clr got %b want 00", {b.wb_wen, b.rst_clr}); end
    endtask
    task automatic test_saturation();
        do_reset();
        b.fu_valid = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (b.conflicts !== 4'(i < 15 ? i + 1 : 15)) begin errors++; $display("FAIL sat_conflicts[%0d] got %0d want %0d", i, b.conflicts, i < 15 ? i + 1 : 15); end
        end
        rst = 1; b.flush = 1; tick(); rst = 0; b.flush = 0;
        checks++; if (b.conflicts !== 4'd0 || b.wb_valid !== 1'b0) begin errors++; $display("FAIL sat_reset got cnt=%0d v=%0d want 0/0", b.conflicts, b.wb_valid); end
        b.fu_valid = 4'b1111; #1;
        checks++; if (b.fu_ready !== 4'b0001) begin errors++; $display("FAIL sat_reset_ptr got %b want 0001", b.fu_ready); end
        b.fu_valid = 0;
    endtask
    task automatic test_random();
        logic [3:0] exp_ready;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            b.fu_valid = 4'($urandom);
            for (int u = 0; u < 4; u++) set_unit(u, 5'($urandom), $urandom);
            b.freeze = ($urandom_range(0, 3) == 0);
            b.flush  = ($urandom_range(0, 9) == 0);
            #1;
            exp_ready = model_ready();
            checks++; if (b.fu_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d] got %b want %b", i, b.fu_ready, exp_ready); end
            tick();
            checks++; if (b.wb_valid !== m_v || b.wb_rd !== m_rd || b.wb_data !== m_data || b.wb_fu !== 2'(m_fu)) begin
                errors++; $display("FAIL rand_wb[%0d] got %0d/%0d/%0h/%0d want %0d/%0d/%0h/%0d", i, b.wb_valid, b.wb_rd, b.wb_data, b.wb_fu, m_v, m_rd, m_data, m_fu); end
            checks++; if (b.wb_wen !== (m_v && m_rd != 0) || b.rst_clr !== (m_v && m_rd != 0)) begin
                errors++; $display("FAIL rand_wen[%0d] got wen=%0d clr=%0d want %0d", i, b.wb_wen, b.rst_clr, m_v && m_rd != 0); end
            checks++; if (b.conflicts !== 4'(m_cnt)) begin errors++; $display("FAIL rand_conflicts[%0d] got %0d want %0d", i, b.conflicts, m_cnt); end
        end
        rst = 0; b.fu_valid = 0; b.freeze = 0; b.flush = 0;
    endtask
    initial begin
        m_ptr = 0; m_fu = 0; m_cnt = 0; m_v = 0; m_rd = 0; m_data = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_freeze();
        test_flush();
        test_rd_zero();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
